// File: rtl/stream_to_ram_pkg.sv
// Shared constants for the stream capture buffer.
// The system bus uses byte addresses; buffer words start at bit WORD_SHIFT.
package stream_to_ram_pkg;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned BUS_DW     = 32;
endpackage

// File: rtl/stream_to_ram_if.sv
// Stream sink and system bus interfaces used by the capture buffer.
// Clock and reset are the shared clk/rstn nets, passed to the block as plain ports.
interface axi4_stream_if #(
  parameter int unsigned DN = 1,
  parameter type         DT = logic [15:0]
);
  DT             TDATA [DN];
  logic [DN-1:0] TKEEP;
  logic          TLAST;
  logic          TVALID;
  logic          TREADY;

  modport m (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport s (input TDATA, TKEEP, TLAST, TVALID, TREADY);
endinterface

interface sys_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport m (output addr, wdata, sel, wen, ren, input rdata, ack, err);
  modport s (input addr, wdata, sel, wen, ren, output rdata, ack, err);
endinterface

// File: rtl/stream_to_ram_ram_sdp.sv
// Simple dual-port RAM: one DN-lane row written per beat, registered read port.
// Storage is intentionally not reset; contents survive rstn.
module stream_to_ram_ram_sdp #(
  parameter int unsigned DN = 1,
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 14
) (
  input  logic              clk,
  input  logic [DN-1:0]     we,
  input  logic [RW-1:0]     waddr,
  input  logic [DN*DW-1:0]  wdata,
  input  logic              re,
  input  logic [RW-1:0]     raddr,
  output logic [DN*DW-1:0]  rdata
);
  logic [DN*DW-1:0] mem [2**RW];

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DN; k++) begin
      if (we[k]) mem[waddr][k*DW +: DW] <= wdata[k*DW +: DW];
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/stream_to_ram.sv
// Capture buffer: writes an always-ready sample stream sequentially into a
// 2^AW-sample RAM, readable over the system bus; any bus write rewinds the pointer.
module stream_to_ram
  import stream_to_ram_pkg::*;
#(
  parameter int unsigned DN = 1,
  parameter type         DT = logic [15:0],
  parameter int unsigned AW = 14
) (
  input  logic       clk,
  input  logic       rstn,
  axi4_stream_if.s   str,
  sys_bus_if.s       bus
);
  localparam int unsigned DW  = $bits(DT);
  localparam int unsigned LW  = $clog2(DN);
  localparam int unsigned LWW = (LW > 0) ? LW : 1;
  localparam int unsigned RW  = (AW > LW) ? AW - LW : 1;

  logic [AW-1:0]       ptr;
  logic                beat;
  logic [RW-1:0]       row_w;
  logic [RW-1:0]       row_r;
  logic [LWW-1:0]      lane_r;
  logic [LWW-1:0]      lane_q;
  logic [DN*DW-1:0]    wrow;
  logic [DN*DW-1:0]    rrow;
  logic [DW-1:0]       lane_val;
  logic                rd_q;
  logic                op_q;
  logic                ack_q;
  logic [BUS_DW-1:0]   rdata_q;

  // Beats arriving while reset is held must not reach the RAM.
  assign beat = str.TVALID & str.TREADY & rstn;

  generate
    if (AW > LW) begin : g_row
      assign row_w = bus.wen ? '0 : ptr[AW-1:LW];
      assign row_r = bus.addr[AW+WORD_SHIFT-1 : LW+WORD_SHIFT];
    end else begin : g_row_single
      assign row_w = '0;
      assign row_r = '0;
    end
    if (LW > 0) begin : g_lane
      assign lane_r = bus.addr[LW+WORD_SHIFT-1 : WORD_SHIFT];
    end else begin : g_lane_single
      assign lane_r = '0;
    end
  endgenerate

  always_comb begin
    wrow = '0;
    for (int unsigned k = 0; k < DN; k++) wrow[k*DW +: DW] = str.TDATA[k];
  end

  stream_to_ram_ram_sdp #(
    .DN (DN),
    .DW (DW),
    .RW (RW)
  ) u_ram (
    .clk   (clk),
    .we    ({DN{beat}}),
    .waddr (row_w),
    .wdata (wrow),
    .re    (bus.ren),
    .raddr (row_r),
    .rdata (rrow)
  );

  // A bus write in the same cycle as a beat rewinds first, so the beat lands at row 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (bus.wen) begin
      ptr <= beat ? AW'(DN) : '0;
    end else if (beat) begin
      ptr <= ptr + AW'(DN);
    end
  end

  always_comb begin
    lane_val = '0;
    for (int unsigned k = 0; k < DN; k++) begin
      if (LWW'(k) == lane_q) lane_val = rrow[k*DW +: DW];
    end
  end

  // Two-stage response: RAM row registered at edge n, lane mux registered at edge n+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q    <= 1'b0;
      op_q    <= 1'b0;
      lane_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_q   <= bus.ren;
      op_q   <= bus.ren | bus.wen;
      lane_q <= lane_r;
      ack_q  <= op_q;
      if (rd_q) rdata_q <= BUS_DW'(lane_val);
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.wdata, bus.sel, bus.addr[31:AW+WORD_SHIFT],
                           bus.addr[WORD_SHIFT-1:0], str.TKEEP, str.TLAST};
endmodule

// File: tb/tb_stream_to_ram.sv
// Bench for stream_to_ram: directed scenarios plus random traffic, all checked
// every cycle against a sample-level model of the buffer and bus response.
module tb_stream_to_ram;
  localparam int unsigned DN    = 1;
  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axi4_stream_if #(.DN(DN), .DT(logic [15:0])) str ();
  sys_bus_if bus ();

  stream_to_ram #(.DN(DN), .DT(logic [15:0]), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .str  (str),
    .bus  (bus)
  );

  typedef struct {
    bit          op;
    bit          rd;
    bit          known;
    int unsigned data;
  } ent_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned mram [int unsigned];
  int unsigned mptr = 0;
  ent_t        pipe [$];
  logic        exp_ack   = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          rd_known  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check at negedge.
  task automatic step();
    ent_t        e;
    ent_t        f;
    int unsigned idx;
    int unsigned base;
    bit          bt;
    @(posedge clk);
    if (!rstn) begin
      pipe.delete();
      mptr      = 0;
      exp_ack   = 1'b0;
      exp_rdata = '0;
      rd_known  = 1'b1;
    end else begin
      idx  = (bus.addr >> 2) % DEPTH;
      base = bus.wen ? 0 : mptr;
      bt   = str.TVALID && str.TREADY;
      e.op    = bus.ren || bus.wen;
      e.rd    = bus.ren;
      e.known = mram.exists(idx) && !(bt && ((idx + DEPTH - base) % DEPTH) < DN);
      e.data  = e.known ? mram[idx] : 0;
      if (bt) for (int unsigned k = 0; k < DN; k++) mram[(base + k) % DEPTH] = str.TDATA[k];
      mptr = (base + (bt ? DN : 0)) % DEPTH;
      pipe.push_back(e);
      exp_ack = 1'b0;
      if (pipe.size() > 1) begin
        f = pipe.pop_front();
        exp_ack = f.op;
        if (f.rd) begin
          rd_known  = f.known;
          exp_rdata = f.data;
        end
      end
    end
    @(negedge clk);
    check("ack", bus.ack, exp_ack);
    if (rd_known) check("rdata", bus.rdata, exp_rdata);
    check("err", bus.err, 32'd0);
  endtask

  task automatic send(input int unsigned v);
    str.TVALID   = 1'b1;
    str.TDATA[0] = v[15:0];
    step();
    str.TVALID   = 1'b0;
  endtask

  task automatic bus_clear();
    bus.addr = '0;
    bus.wen  = 1'b1;
    step();
    bus.wen  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.ren  = 1'b1;
    step();
    bus.ren  = 1'b0;
    step();
    check("read_ack", bus.ack, 32'd1);
    d = bus.rdata;
  endtask

  initial begin
    int unsigned exp1 [8] = '{0, 0, 1, 2, 2, 3, 3, 3};
    logic [31:0] d;

    rstn         = 1'b0;
    str.TVALID   = 1'b0;
    str.TREADY   = 1'b1;
    str.TKEEP    = '1;
    str.TLAST    = 1'b0;
    str.TDATA[0] = '0;
    bus.addr     = '0;
    bus.wdata    = 32'hdead_beef;
    bus.sel      = 4'hf;
    bus.wen      = 1'b0;
    bus.ren      = 1'b0;
    @(negedge clk);
    check("reset_ack", bus.ack, 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();

    // Sequential capture, then rewind and read back.
    bus_clear();
    foreach (exp1[i]) send(exp1[i]);
    send(16'h77);
    bus_clear();
    for (int unsigned i = 0; i < 8; i++) begin
      bus_read(32'(i * 4), d);
      check("seq_read", d, exp1[i]);
    end
    bus_read(32'd32, d);
    check("ptr_after_8", d, 32'h77);

    // Wrap: DEPTH+3 samples overwrite the first three locations.
    bus_clear();
    for (int unsigned i = 0; i < DEPTH + 3; i++) send(i);
    for (int unsigned i = 0; i < 4; i++) begin
      bus_read(32'(i * 4), d);
      check("wrap_read", d, (i < 3) ? DEPTH + i : i);
    end

    // Alias: upper address bits ignored, result zero-extended.
    bus_read(32'(DEPTH * 4 + 8), d);
    check("alias_read", d, DEPTH + 2);
    d = d >> 16;
    check("alias_upper_zero", d, 32'd0);

    // Bus write coinciding with a beat: beat goes to 0, pointer becomes 1.
    bus_clear();
    for (int unsigned i = 0; i < 10; i++) send(100 + i);
    str.TVALID   = 1'b1;
    str.TDATA[0] = 16'h55;
    bus.wen      = 1'b1;
    step();
    bus.wen      = 1'b0;
    str.TVALID   = 1'b0;
    send(16'h66);
    bus_read(32'd0, d);
    check("clear_beat_0", d, 32'h55);
    bus_read(32'd4, d);
    check("clear_beat_1", d, 32'h66);
    bus_read(32'd8, d);
    check("clear_keep_2", d, 32'd102);

    // Reset mid-stream with a read in flight.
    bus_clear();
    for (int unsigned i = 0; i < 5; i++) send(16'h200 + i);
    str.TVALID   = 1'b1;
    str.TDATA[0] = 16'hbeef;
    bus.addr     = '0;
    bus.ren      = 1'b1;
    step();
    bus.ren      = 1'b0;
    rstn         = 1'b0;
    #1;
    check("rst_ack_async", bus.ack, 32'd0);
    step();
    check("rst_ack_held", bus.ack, 32'd0);
    step();
    str.TVALID   = 1'b0;
    rstn         = 1'b1;
    step();
    send(16'ha1);
    send(16'ha2);
    bus_read(32'd0, d);
    check("post_rst_0", d, 32'ha1);
    bus_read(32'd4, d);
    check("post_rst_1", d, 32'ha2);
    bus_read(32'd20, d);
    check("pre_rst_beat", d, 32'hbeef);

    // Random traffic including back-to-back reads, writes and aliased addresses.
    for (int unsigned n = 0; n < 600; n++) begin
      str.TVALID   = ($urandom % 2) == 0;
      str.TDATA[0] = 16'($urandom);
      bus.ren      = ($urandom % 3) == 0;
      bus.wen      = ($urandom % 16) == 0;
      bus.addr     = $urandom;
      step();
    end
    str.TVALID = 1'b0;
    bus.ren    = 1'b0;
    bus.wen    = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
